// File: rtl/data_fetch_if.sv
// data_fetch_if: memory-side and channel-side handshake signals of the fetch stage.
interface data_fetch_if;
   logic [31:0] in_data;
   logic        in_rts;
   logic        in_rtr;
   logic [16:0] mem_ptr;
   logic [31:0] out_data;
   logic        r_rts, g_rts, b_rts;
   logic        r_rtr, g_rtr, b_rtr;
   modport master (
      input  in_data, in_rts, r_rtr, g_rtr, b_rtr,
      output in_rtr, mem_ptr, out_data, r_rts, g_rts, b_rts
   );
   modport slave (
      output in_data, in_rts, r_rtr, g_rtr, b_rtr,
      input  in_rtr, mem_ptr, out_data, r_rts, g_rts, b_rts
   );
endinterface

// File: rtl/data_fetch_unit.sv
// data_fetch_unit: sequential word fetch into a 2-entry FIFO, dealt round-robin to R/G/B consumers.
module data_fetch_unit #(
   parameter logic [16:0] ADDR_LAST = 17'h1FFFF
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         en,
   data_fetch_if.master bus
);
   typedef enum logic [2:0] {S_R = 3'b001, S_G = 3'b010, S_B = 3'b100} state_t;
   state_t      state, state_nxt;
   logic [31:0] q0, q1;
   logic [1:0]  rd_addr, wr_addr;
   logic [16:0] mem_ptr;
   logic        full, empty, in_xfc, out_xfc;
   // Pointers carry a wrap bit above the 1-bit index to tell full from empty.
   assign full     = (rd_addr[0] == wr_addr[0]) && (rd_addr[1] != wr_addr[1]);
   assign empty    = rd_addr == wr_addr;
   assign in_xfc   = bus.in_rts & bus.in_rtr;
   assign out_xfc  = (bus.r_rts & bus.r_rtr) | (bus.g_rts & bus.g_rtr) | (bus.b_rts & bus.b_rtr);
   assign bus.in_rtr   = !full;
   assign bus.mem_ptr  = mem_ptr;
   assign bus.out_data = rd_addr[0] ? q1 : q0;
   always_ff @(posedge clk) begin
      if (!rst_) begin
         mem_ptr <= '0;
         rd_addr <= '0;
         wr_addr <= '0;
         q0      <= '0;
         q1      <= '0;
      end else if (en) begin
         mem_ptr <= '0;
         rd_addr <= '0;
         wr_addr <= '0;
      end else begin
         if (in_xfc) begin
            if (wr_addr[0]) q1 <= bus.in_data;
            else q0 <= bus.in_data;
            wr_addr <= wr_addr + 2'd1;
            mem_ptr <= (mem_ptr == ADDR_LAST) ? 17'd0 : mem_ptr + 17'd1;
         end
         if (out_xfc) rd_addr <= rd_addr + 2'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_ || en) state <= S_R;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = !out_xfc ? state : (state == S_R) ? S_G : (state == S_G) ? S_B : S_R;
   end
   always_comb begin
      bus.r_rts = !empty && state == S_R;
      bus.g_rts = !empty && state == S_G;
      bus.b_rts = !empty && state == S_B;
   end
endmodule

// File: tb/tb_data_fetch_unit.sv
// tb_data_fetch_unit: directed checks of reset, streaming, backpressure, restart, wrap and mid-run reset.
module tb_data_fetch_unit;
   logic clk = 1'b0;
   logic rst_, en;
   int   total = 0;
   int   bad = 0;
   data_fetch_if bus ();
   data_fetch_if bus2 ();
   data_fetch_unit dut (.clk(clk), .rst_(rst_), .en(en), .bus(bus));
   data_fetch_unit #(.ADDR_LAST(17'd4)) dut2 (.clk(clk), .rst_(rst_), .en(en), .bus(bus2));
   always #5 clk = ~clk;
   // Source model: memory[i] = 32'h1000_0000 + i, presented combinationally.
   assign bus.in_data  = 32'h1000_0000 + {15'd0, bus.mem_ptr};
   assign bus2.in_data = 32'h1000_0000 + {15'd0, bus2.mem_ptr};
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_ptr"}, {15'd0, bus.mem_ptr}, 0);
      chk({tag, "_rtr"}, {31'd0, bus.in_rtr}, 1);
      chk({tag, "_rts"}, {29'd0, bus.b_rts, bus.g_rts, bus.r_rts}, 0);
      chk({tag, "_data"}, bus.out_data, 0);
   endtask
   function automatic logic [31:0] rts(input logic b, input logic g, input logic r);
      return {29'd0, b, g, r};
   endfunction
   logic [16:0] wrap_ptr [7];
   logic [2:0]  wrap_rts [7];
   initial begin
      wrap_ptr = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd4, 17'd0, 17'd1};
      wrap_rts = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
      rst_ = 1'b0; en = 1'b0;
      bus.in_rts = 1'b0; bus.r_rtr = 1'b1; bus.g_rtr = 1'b1; bus.b_rtr = 1'b1;
      bus2.in_rts = 1'b0; bus2.r_rtr = 1'b1; bus2.g_rtr = 1'b1; bus2.b_rtr = 1'b1;
      step();
      rst_ = 1'b1;
      chk_reset("reset");
      repeat (5) step();
      chk_reset("idle");
      // Streaming: one word per cycle, channels R,G,B,R
      bus.in_rts = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stream_data", bus.out_data, 32'h1000_0000 + k);
         chk("stream_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 32'd1 << (k % 3));
         chk("stream_ptr", {15'd0, bus.mem_ptr}, k + 1);
      end
      // Backpressure on G
      bus.g_rtr = 1'b0;
      step();
      chk("bp_data0", bus.out_data, 32'h1000_0004);
      chk("bp_rts0", rts(bus.b_rts, bus.g_rts, bus.r_rts), 2);
      chk("bp_rtr0", {31'd0, bus.in_rtr}, 1);
      step();
      chk("bp_rtr1", {31'd0, bus.in_rtr}, 0);
      chk("bp_ptr1", {15'd0, bus.mem_ptr}, 6);
      step();
      chk("bp_hold_data", bus.out_data, 32'h1000_0004);
      chk("bp_hold_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 2);
      chk("bp_hold_ptr", {15'd0, bus.mem_ptr}, 6);
      chk("bp_hold_rtr", {31'd0, bus.in_rtr}, 0);
      bus.g_rtr = 1'b1;
      step();
      chk("rel_data0", bus.out_data, 32'h1000_0005);
      chk("rel_rts0", rts(bus.b_rts, bus.g_rts, bus.r_rts), 4);
      chk("rel_ptr0", {15'd0, bus.mem_ptr}, 6);
      chk("rel_rtr0", {31'd0, bus.in_rtr}, 1);
      step();
      chk("rel_data1", bus.out_data, 32'h1000_0006);
      chk("rel_rts1", rts(bus.b_rts, bus.g_rts, bus.r_rts), 1);
      chk("rel_ptr1", {15'd0, bus.mem_ptr}, 7);
      // Fill to 2 words with state S_B, then restart
      step();
      step();
      bus.b_rtr = 1'b0;
      step();
      chk("pre_en_rtr", {31'd0, bus.in_rtr}, 0);
      chk("pre_en_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 4);
      chk("pre_en_data", bus.out_data, 32'h1000_0008);
      en = 1'b1; bus.b_rtr = 1'b1;
      step();
      en = 1'b0;
      chk("en_ptr", {15'd0, bus.mem_ptr}, 0);
      chk("en_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 0);
      chk("en_rtr", {31'd0, bus.in_rtr}, 1);
      step();
      chk("en_first_data", bus.out_data, 32'h1000_0000);
      chk("en_first_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 1);
      step();
      chk("en_second_data", bus.out_data, 32'h1000_0001);
      chk("en_second_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 2);
      chk("en_second_ptr", {15'd0, bus.mem_ptr}, 2);
      // Full FIFO with b_rts high, then reset
      bus.b_rtr = 1'b0;
      step();
      step();
      chk("full_rtr", {31'd0, bus.in_rtr}, 0);
      chk("full_rts", rts(bus.b_rts, bus.g_rts, bus.r_rts), 4);
      chk("full_data", bus.out_data, 32'h1000_0002);
      rst_ = 1'b0;
      step();
      rst_ = 1'b1;
      bus.in_rts = 1'b0; bus.b_rtr = 1'b1;
      chk_reset("midrst");
      // Wrap with ADDR_LAST = 4
      bus2.in_rts = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk("wrap_ptr", {15'd0, bus2.mem_ptr}, {15'd0, wrap_ptr[k]});
         step();
         chk("wrap_data", bus2.out_data, 32'h1000_0000 + {15'd0, wrap_ptr[k]});
         chk("wrap_rts", rts(bus2.b_rts, bus2.g_rts, bus2.r_rts), {29'd0, wrap_rts[k]});
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
